// File: rtl/logic_serial_ctrl.sv
// Bit-serial sequencer: walks one external 1-bit logic unit across WIDTH-bit
// operands, LSB first, assembling the result and pulsing done at the end.
module logic_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             lu_a,
    output logic             lu_b,
    output logic [1:0]       lu_control,
    input  logic             lu_out
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                // DONE accepts a new request exactly like IDLE for back-to-back ops
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        op_q   <= op;
                        result <= '0;
                        idx    <= '0;
                        state  <= RUN;
                        busy   <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    result[idx] <= lu_out;
                    if (idx == LAST) begin
                        idx   <= '0;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Logic unit inputs are parked at zero outside RUN
    always_comb begin
        lu_a       = 1'b0;
        lu_b       = 1'b0;
        lu_control = 2'd0;
        if (state == RUN) begin
            lu_a       = a_q[idx];
            lu_b       = b_q[idx];
            lu_control = op_q;
        end
    end

endmodule
